// File: rtl/rv32i_types.sv
// Shared types for the rename / retirement slice of the core.
// Provides the register index typedefs, the retire-lane bundle struct and
// the machine-wide sizing constants used by the retirement RAT.
package rv32i_types;

    localparam int ARCH_REGS = 32;   // architectural registers, x0 hardwired zero
    localparam int PHYS_W    = 6;    // physical register index width
    localparam int SS        = 2;    // default retire lanes per cycle
    localparam int CNT_W     = 64;   // default retired-instruction counter width

    typedef logic [PHYS_W-1:0] phys_reg_t;
    typedef logic [4:0]        arch_reg_t;

    // One retirement lane as seen by the bundle resolver.
    typedef struct packed {
        logic      valid;
        arch_reg_t rd_arch;
        phys_reg_t rd_phys;
    } retire_lane_t;

endpackage

// File: rtl/rrat_bundle_resolve.sv
// Combinational resolution of one retirement bundle.
// Ports:
//   lanes    in   per-lane {fire, rd_arch, rd_phys}; lane 0 is oldest
//   map      in   current retired arch->phys map
//   fl_push  out  lane i frees a physical register
//   fl_phys  out  physical register freed by lane i (0 when not pushing)
//   wr_en    out  arch reg r is written by this bundle
//   wr_phys  out  phys reg written to arch reg r by its youngest writer
module rrat_bundle_resolve
    import rv32i_types::*;
#(
    parameter int SS = rv32i_types::SS
) (
    input  retire_lane_t [SS-1:0]        lanes,
    input  phys_reg_t    [ARCH_REGS-1:0] map,
    output logic         [SS-1:0]        fl_push,
    output phys_reg_t    [SS-1:0]        fl_phys,
    output logic         [ARCH_REGS-1:0] wr_en,
    output phys_reg_t    [ARCH_REGS-1:0] wr_phys
);

    logic [SS-1:0] lane_wr;

    always_comb begin
        // NOTE: every output gets a default before any conditional write, so
        // no path through the block leaves a value held and no latch is inferred.
        lane_wr = '0;
        fl_push = '0;
        fl_phys = '0;
        wr_en   = '0;
        wr_phys = '0;

        for (int i = 0; i < SS; i++) begin
            lane_wr[i] = lanes[i].valid && (lanes[i].rd_arch != '0);
        end

        // A lane's superseded mapping is whatever an older lane in the same
        // bundle just bound to that arch reg; ascending j leaves the youngest
        // such older lane in place, otherwise the retired map entry stands.
        for (int i = 0; i < SS; i++) begin
            fl_push[i] = lane_wr[i];
            if (lane_wr[i]) begin
                fl_phys[i] = map[lanes[i].rd_arch];
                for (int j = 0; j < i; j++) begin
                    if (lane_wr[j] && (lanes[j].rd_arch == lanes[i].rd_arch)) begin
                        fl_phys[i] = lanes[j].rd_phys;
                    end
                end
            end
        end

        // Final writer per arch reg: ascending lane order lets the youngest win.
        for (int r = 0; r < ARCH_REGS; r++) begin
            for (int i = 0; i < SS; i++) begin
                if (lane_wr[i] && (lanes[i].rd_arch == arch_reg_t'(r))) begin
                    wr_en[r]   = 1'b1;
                    wr_phys[r] = lanes[i].rd_phys;
                end
            end
        end
    end

endmodule

// File: rtl/retired_rat_ss.sv
// Retired (architectural) register alias table for an SS-wide retire stage.
// Applies up to SS in-order retirements per cycle, returns superseded
// physical registers to the free list, snapshots the map on flush and
// counts retired instructions.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ret_valid       lanes retiring this cycle (contiguous from lane 0)
//   ret_rd_arch     destination arch reg per lane
//   ret_rd_phys     newly bound physical reg per lane
//   ret_ready       retirement accepted this cycle
//   fl_ready        free list can take SS pushes
//   fl_push/fl_phys freed physical regs, combinational with the retire
//   flush_req       request a map snapshot
//   flush_valid     one-cycle snapshot strobe, flush_map holds the snapshot
//   retired_count   total retired instructions (wraps)
module retired_rat_ss
    import rv32i_types::*;
#(
    parameter int SS    = rv32i_types::SS,
    parameter int CNT_W = rv32i_types::CNT_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [SS-1:0]                     ret_valid,
    input  logic [SS-1:0][4:0]                ret_rd_arch,
    input  logic [SS-1:0][PHYS_W-1:0]         ret_rd_phys,
    output logic                              ret_ready,
    input  logic                              fl_ready,
    output logic [SS-1:0]                     fl_push,
    output logic [SS-1:0][PHYS_W-1:0]         fl_phys,
    input  logic                              flush_req,
    output logic                              flush_valid,
    output logic [ARCH_REGS-1:0][PHYS_W-1:0]  flush_map,
    output logic [CNT_W-1:0]                  retired_count
);

    phys_reg_t    [ARCH_REGS-1:0] map;
    phys_reg_t    [ARCH_REGS-1:0] map_next;
    logic         [ARCH_REGS-1:0] wr_en;
    phys_reg_t    [ARCH_REGS-1:0] wr_phys;
    logic         [SS-1:0]        fire;
    retire_lane_t [SS-1:0]        lanes;
    logic         [CNT_W-1:0]     cnt_inc;

    assign ret_ready = !rst && fl_ready;
    assign fire      = ret_valid & {SS{ret_ready}};

    always_comb begin
        for (int i = 0; i < SS; i++) begin
            lanes[i].valid   = fire[i];
            lanes[i].rd_arch = ret_rd_arch[i];
            lanes[i].rd_phys = ret_rd_phys[i];
        end
    end

    rrat_bundle_resolve #(.SS(SS)) u_resolve (
        .lanes   (lanes),
        .map     (map),
        .fl_push (fl_push),
        .fl_phys (fl_phys),
        .wr_en   (wr_en),
        .wr_phys (wr_phys)
    );

    // Map as it stands after this cycle's commits; also the flush snapshot,
    // so a retirement in the flush cycle is visible to the front end.
    always_comb begin
        map_next = map;
        for (int r = 0; r < ARCH_REGS; r++) begin
            if (wr_en[r]) map_next[r] = wr_phys[r];
        end
    end

    always_comb begin
        cnt_inc = '0;
        for (int i = 0; i < SS; i++) begin
            if (fire[i]) cnt_inc = cnt_inc + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the map is architectural state and must restart as identity,
        // so unlike a data RAM every entry is reset explicitly.
        if (rst) begin
            for (int r = 0; r < ARCH_REGS; r++) begin
                map[r]       <= PHYS_W'(r);
                flush_map[r] <= PHYS_W'(r);
            end
            flush_valid   <= 1'b0;
            retired_count <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values,
            // independent of statement order.
            map           <= map_next;
            flush_valid   <= flush_req;
            retired_count <= retired_count + cnt_inc;
            if (flush_req) flush_map <= map_next;
        end
    end

    // Retirement is in order; a hole in ret_valid means the ROB misbehaved.
    a_ret_valid_contig : assert property (
        @(posedge clk) disable iff (rst)
        ((ret_valid & (ret_valid + SS'(1))) == '0)
    ) else $error("ret_valid not contiguous from lane 0: %b", ret_valid);

endmodule

// File: tb/tb_retired_rat_ss.sv
module tb_retired_rat_ss;
    localparam int SS     = 2;
    localparam int PHYS_W = 6;
    localparam int AREGS  = 32;
    localparam int CNT_W  = 64;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [SS-1:0]                 ret_valid;
    logic [SS-1:0][4:0]            ret_rd_arch;
    logic [SS-1:0][PHYS_W-1:0]     ret_rd_phys;
    logic                          ret_ready;
    logic                          fl_ready;
    logic [SS-1:0]                 fl_push;
    logic [SS-1:0][PHYS_W-1:0]     fl_phys;
    logic                          flush_req;
    logic                          flush_valid;
    logic [AREGS-1:0][PHYS_W-1:0]  flush_map;
    logic [CNT_W-1:0]              retired_count;

    int n_tests = 0;
    int n_fail  = 0;

    retired_rat_ss #(.SS(SS), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .ret_valid     (ret_valid),
        .ret_rd_arch   (ret_rd_arch),
        .ret_rd_phys   (ret_rd_phys),
        .ret_ready     (ret_ready),
        .fl_ready      (fl_ready),
        .fl_push       (fl_push),
        .fl_phys       (fl_phys),
        .flush_req     (flush_req),
        .flush_valid   (flush_valid),
        .flush_map     (flush_map),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ret_valid   = '0;
        ret_rd_arch = '0;
        ret_rd_phys = '0;
        flush_req   = 1'b0;
    endtask

    task automatic lanes(input logic [1:0] v, input logic [4:0] a0, input logic [5:0] p0,
                         input logic [4:0] a1, input logic [5:0] p1);
        ret_valid      = v;
        ret_rd_arch[0] = a0;
        ret_rd_phys[0] = p0;
        ret_rd_arch[1] = a1;
        ret_rd_phys[1] = p1;
        #1;
    endtask

    // Request a snapshot on an idle cycle and check one map entry.
    task automatic snap_check(input string tag, input int idx, input logic [5:0] exp);
        idle();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        check({tag, "_valid"}, {63'd0, flush_valid}, 64'd1);
        check(tag, {58'd0, flush_map[idx]}, {58'd0, exp});
    endtask

    initial begin
        rst      = 1'b1;
        fl_ready = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset then idle
        check("rst_ready",   {63'd0, ret_ready},   64'd1);
        check("rst_push",    {62'd0, fl_push},     64'd0);
        check("rst_count",   retired_count,        64'd0);
        check("rst_fvalid",  {63'd0, flush_valid}, 64'd0);
        snap_check("rst_map5", 5, 6'd5);
        check("rst_map0", {58'd0, flush_map[0]}, 64'd0);
        tick();
        check("pulse_drop", {63'd0, flush_valid}, 64'd0);

        // Single retire
        lanes(2'b01, 5'd3, 6'd40, 5'd0, 6'd0);
        check("s_push",  {62'd0, fl_push},    64'd1);
        check("s_phys0", {58'd0, fl_phys[0]}, 64'd3);
        check("s_phys1", {58'd0, fl_phys[1]}, 64'd0);
        tick();
        idle();
        check("s_count", retired_count, 64'd1);
        snap_check("s_map3", 3, 6'd40);

        // Same-rd bundle
        lanes(2'b11, 5'd7, 6'd33, 5'd7, 6'd34);
        check("d_push",  {62'd0, fl_push},    64'd3);
        check("d_phys0", {58'd0, fl_phys[0]}, 64'd7);
        check("d_phys1", {58'd0, fl_phys[1]}, 64'd33);
        tick();
        idle();
        check("d_count", retired_count, 64'd3);
        snap_check("d_map7", 7, 6'd34);

        // Distinct-rd bundle: lane0 frees previously retired 40
        lanes(2'b11, 5'd3, 6'd41, 5'd4, 6'd42);
        check("u_phys0", {58'd0, fl_phys[0]}, 64'd40);
        check("u_phys1", {58'd0, fl_phys[1]}, 64'd4);
        tick();
        idle();
        check("u_count", retired_count, 64'd5);
        snap_check("u_map3", 3, 6'd41);
        check("u_map4", {58'd0, flush_map[4]}, 64'd42);

        // x0 destination
        lanes(2'b01, 5'd0, 6'd20, 5'd0, 6'd0);
        check("z_push",  {62'd0, fl_push},    64'd0);
        check("z_phys0", {58'd0, fl_phys[0]}, 64'd0);
        tick();
        idle();
        check("z_count", retired_count, 64'd6);
        snap_check("z_map0", 0, 6'd0);

        // x0 in lane 0, real write in lane 1
        lanes(2'b11, 5'd0, 6'd21, 5'd5, 6'd45);
        check("zm_push",  {62'd0, fl_push},    64'd2);
        check("zm_phys1", {58'd0, fl_phys[1]}, 64'd5);
        tick();
        idle();
        check("zm_count", retired_count, 64'd8);

        // Backpressure
        fl_ready = 1'b0;
        lanes(2'b11, 5'd3, 6'd60, 5'd3, 6'd61);
        check("bp_ready", {63'd0, ret_ready}, 64'd0);
        check("bp_push",  {62'd0, fl_push},   64'd0);
        tick();
        idle();
        fl_ready = 1'b1;
        check("bp_count", retired_count, 64'd8);
        snap_check("bp_map3", 3, 6'd41);

        // Flush with same-cycle retire
        lanes(2'b01, 5'd9, 6'd50, 5'd0, 6'd0);
        flush_req = 1'b1;
        tick();
        idle();
        check("f_valid", {63'd0, flush_valid},  64'd1);
        check("f_map9",  {58'd0, flush_map[9]}, 64'd50);
        check("f_count", retired_count,         64'd9);

        // Held flush: each pulse carries a fresh snapshot
        lanes(2'b01, 5'd9, 6'd51, 5'd0, 6'd0);
        flush_req = 1'b1;
        tick();
        check("h1_valid", {63'd0, flush_valid},  64'd1);
        check("h1_map9",  {58'd0, flush_map[9]}, 64'd51);
        ret_valid = '0;
        tick();
        check("h2_valid", {63'd0, flush_valid}, 64'd1);
        idle();
        tick();
        check("h3_valid", {63'd0, flush_valid}, 64'd0);

        // Reset mid-bundle with pending flush
        lanes(2'b01, 5'd9, 6'd52, 5'd0, 6'd0);
        flush_req = 1'b1;
        rst = 1'b1;
        #1;
        check("r_ready", {63'd0, ret_ready}, 64'd0);
        check("r_push",  {62'd0, fl_push},   64'd0);
        tick();
        rst = 1'b0;
        idle();
        check("r_fvalid", {63'd0, flush_valid}, 64'd0);
        check("r_count",  retired_count,        64'd0);
        snap_check("r_map9", 9, 6'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
